// File: rtl/tx_burst_ctrl.sv
// tx_burst_ctrl: AT86RF215 TX burst sequencer - lead zeros, stream samples, tail zeros, underrun handling.
// Latency: do_tx rises one rx_clk after tx_req is sampled; each sample lands on the edge ending its strobe.
// Backpressure: s_ready is high only for the one strobe cycle in DATA; a strobe with no s_valid is an underrun.
//
// Ports:
//   rx_clk, rst_ddr          sole clock, synchronous active-high reset
//   tx_req                   level request for a burst
//   s_valid/s_data/s_last    host sample stream {I[12:0], Q[12:0]}; s_ready accepts it
//   next_data                serializer request level; each rising edge is one strobe
//   data_i, data_q, do_tx    sample and TX enable to the DDR serializer
//   busy, burst_done         not-IDLE flag, one-cycle pulse when a tail completes
//   underrun, underrun_cnt   starved-strobe pulse, saturating starved-strobe total
//
// Build option TX_UNDERRUN_HOLD_EN: defined -> an underrun repeats the last sample,
// undefined -> an underrun sends zero. Counting and abort are the same in both builds.
module tx_burst_ctrl #(
  parameter int PRE_ZERO     = 16,
  parameter int POST_ZERO    = 16,
  parameter int UNDERRUN_MAX = 8
) (
  input  logic        rx_clk,
  input  logic        rst_ddr,
  input  logic        tx_req,
  input  logic        s_valid,
  input  logic [25:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        next_data,
  output logic [12:0] data_i,
  output logic [12:0] data_q,
  output logic        do_tx,
  output logic        busy,
  output logic        burst_done,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam logic [7:0] PRE_L  = 8'(PRE_ZERO);
  localparam logic [7:0] POST_L = 8'(POST_ZERO);
  localparam logic [7:0] UMAX_L = 8'(UNDERRUN_MAX);

  typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} state_t;

  state_t     state;
  logic       next_data_q;
  logic       req;
  logic       xfer;
  logic [7:0] lead_cnt;
  logic [7:0] tail_cnt;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;

  assign req        = next_data & ~next_data_q;
  // A dropped tx_req blocks the transfer on the strobe that exits DATA.
  assign s_ready    = ~rst_ddr & req & tx_req & (state == DATA);
  assign xfer       = s_ready & s_valid;
  assign starve_nxt = starve_cnt + 8'd1;

  always_ff @(posedge rx_clk) begin
    if (rst_ddr) begin
      state        <= IDLE;
      next_data_q  <= 1'b0;
      lead_cnt     <= '0;
      tail_cnt     <= '0;
      starve_cnt   <= '0;
      data_i       <= '0;
      data_q       <= '0;
      do_tx        <= 1'b0;
      busy         <= 1'b0;
      burst_done   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      next_data_q <= next_data;
      burst_done  <= 1'b0;
      underrun    <= 1'b0;

      case (state)
        IDLE: begin
          if (tx_req) begin
            state      <= LEAD;
            lead_cnt   <= PRE_L;
            starve_cnt <= '0;
            do_tx      <= 1'b1;
            busy       <= 1'b1;
          end
        end

        LEAD: begin
          if (req) begin
            lead_cnt <= lead_cnt - 8'd1;
            if (!tx_req) begin
              state    <= TAIL;
              tail_cnt <= POST_L;
            end else if (lead_cnt == 8'd1) begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (req) begin
            if (xfer) begin
              data_i     <= s_data[25:13];
              data_q     <= s_data[12:0];
              starve_cnt <= '0;
              if (s_last) begin
                state    <= TAIL;
                tail_cnt <= POST_L;
              end
            end else if (!s_valid) begin
              // Starved strobe: counted even when tx_req has just dropped.
              underrun   <= 1'b1;
              starve_cnt <= starve_nxt;
              if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
              end
`ifdef TX_UNDERRUN_HOLD_EN
              // data_i/data_q already hold the last sample sent (zero before the first transfer).
`else
              data_i <= '0;
              data_q <= '0;
`endif
              if (!tx_req || starve_nxt == UMAX_L) begin
                state    <= TAIL;
                tail_cnt <= POST_L;
              end
            end else begin
              // Sample offered but tx_req dropped: leave it in the stream, send zero.
              data_i   <= '0;
              data_q   <= '0;
              state    <= TAIL;
              tail_cnt <= POST_L;
            end
          end
        end

        TAIL: begin
          if (req) begin
            data_i   <= '0;
            data_q   <= '0;
            tail_cnt <= tail_cnt - 8'd1;
            if (tail_cnt == 8'd1) begin
              state      <= IDLE;
              do_tx      <= 1'b0;
              busy       <= 1'b0;
              burst_done <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
